// File: rtl/ucomp_pkg.sv
// Shared definitions for the ucomputer_gen microcomputer.
//   - OP_* : instruction opcodes (upper OPC_W bits of the instruction word)
//   - state_t : microsequencer steps T0..T4 plus the terminal HALT state
package ucomp_pkg;

    localparam int OP_NOP = 0;
    localparam int OP_LDA = 1;
    localparam int OP_ADD = 2;
    localparam int OP_SUB = 3;
    localparam int OP_STA = 4;
    localparam int OP_LDI = 5;
    localparam int OP_JMP = 6;
    localparam int OP_JC  = 7;
    localparam int OP_JZ  = 8;
    localparam int OP_OUT = 14;
    localparam int OP_HLT = 15;

    typedef enum logic [2:0] {
        ST_T0   = 3'd0,
        ST_T1   = 3'd1,
        ST_T2   = 3'd2,
        ST_T3   = 3'd3,
        ST_T4   = 3'd4,
        ST_HALT = 3'd5
    } state_t;

endpackage

// File: rtl/alu_gen.sv
// Combinational adder/subtractor for the accumulator datapath.
// Ports:
//   a, b   : operands
//   sub    : 0 = a+b, 1 = a-b
//   result : a+b or a-b modulo 2**DATA_W
//   carry  : carry-out on add; no-borrow (a >= b unsigned) on subtract
//   zero   : result == 0
module alu_gen #(
    parameter int DATA_W = 8
) (
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    input  logic              sub,
    output logic [DATA_W-1:0] result,
    output logic              carry,
    output logic              zero
);

    logic [DATA_W-1:0] b_eff;
    logic [DATA_W:0]   sum;

    // Subtraction as a + ~b + 1: the carry-out is then exactly "no borrow".
    assign b_eff  = sub ? ~b : b;
    assign sum    = {1'b0, a} + {1'b0, b_eff} + {{DATA_W{1'b0}}, sub};
    assign result = sum[DATA_W-1:0];
    assign carry  = sum[DATA_W];
    assign zero   = (sum[DATA_W-1:0] == '0);

endmodule

// File: rtl/ucomputer_gen.sv
// SAP-style accumulator microcomputer with a variable-length microsequencer.
// Optional build macro: UCOMP_BRANCH_EN enables JMP/JC/JZ; without it those
// opcodes execute as 3-cycle NOPs (flags are still computed by ADD/SUB).
// Ports:
//   clk, clear             : rising-edge clock, asynchronous active-low reset
//   run                    : 1 = execute, 0 = pause at the next T0
//   prog_we/addr/data      : host program-load port
//   out, out_valid         : output register and its one-cycle update strobe
//   halted                 : high after HLT until clear
//   dbg_state, dbg_pc, dbg_a, dbg_carry, dbg_zero : observation of internal state
// Handshake: out_valid is high for exactly the one cycle in which out carries a
// freshly written value (there is no back-pressure); prog_we is accepted only in
// a cycle where the machine sits in T0 with run low, and is otherwise dropped.
module ucomputer_gen
    import ucomp_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 4,
    parameter int OPC_W  = 4
) (
    input  logic              clk,
    input  logic              clear,
    input  logic              run,
    input  logic              prog_we,
    input  logic [ADDR_W-1:0] prog_addr,
    input  logic [DATA_W-1:0] prog_data,
    output logic [DATA_W-1:0] out,
    output logic              out_valid,
    output logic              halted,
    output state_t            dbg_state,
    output logic [ADDR_W-1:0] dbg_pc,
    output logic [DATA_W-1:0] dbg_a,
    output logic              dbg_carry,
    output logic              dbg_zero
);

    localparam int DEPTH = 2 ** ADDR_W;

    if (OPC_W + ADDR_W > DATA_W) begin : g_bad_widths
        $error("ucomputer_gen: OPC_W + ADDR_W must not exceed DATA_W");
    end

    state_t            state, state_n;
    logic [ADDR_W-1:0] pc, mar;
    logic [DATA_W-1:0] ir, a, b;
    logic              carry, zero;
    logic [DATA_W-1:0] mem [DEPTH];

    logic [31:0]       opc;
    logic [ADDR_W-1:0] operand;
    logic [DATA_W-1:0] ram_rd;
    logic [DATA_W-1:0] alu_res;
    logic              alu_carry, alu_zero;
    logic              prog_ok;

    // Control strobes decoded from the current step.
    logic ld_mar_pc, ld_ir, ld_mar_op, ld_a_mem, ld_b, ld_alu;
    logic ram_we, ld_a_imm, ld_pc_op, ld_out;

    assign opc     = 32'(ir[DATA_W-1 -: OPC_W]);
    assign operand = ir[ADDR_W-1:0];
    assign ram_rd  = mem[mar];
    assign prog_ok = prog_we && (state == ST_T0) && !run;

    alu_gen #(.DATA_W(DATA_W)) u_alu (
        .a      (a),
        .b      (b),
        .sub    (opc == OP_SUB),
        .result (alu_res),
        .carry  (alu_carry),
        .zero   (alu_zero)
    );

    always_ff @(posedge clk or negedge clear) begin
        if (!clear) state <= ST_T0;
        else        state <= state_n;
    end

    always_comb begin
        state_n   = state;
        ld_mar_pc = 1'b0;
        ld_ir     = 1'b0;
        ld_mar_op = 1'b0;
        ld_a_mem  = 1'b0;
        ld_b      = 1'b0;
        ld_alu    = 1'b0;
        ram_we    = 1'b0;
        ld_a_imm  = 1'b0;
        ld_pc_op  = 1'b0;
        ld_out    = 1'b0;
        case (state)
            // Instruction boundary: the only place run is looked at.
            ST_T0: begin
                if (run) begin
                    ld_mar_pc = 1'b1;
                    state_n   = ST_T1;
                end
            end
            ST_T1: begin
                ld_ir   = 1'b1;
                state_n = ST_T2;
            end
            ST_T2: begin
                state_n = ST_T0;
                case (opc)
                    OP_LDA, OP_ADD, OP_SUB, OP_STA: begin
                        ld_mar_op = 1'b1;
                        state_n   = ST_T3;
                    end
                    OP_LDI: ld_a_imm = 1'b1;
`ifdef UCOMP_BRANCH_EN
                    OP_JMP: ld_pc_op = 1'b1;
                    OP_JC:  ld_pc_op = carry;
                    OP_JZ:  ld_pc_op = zero;
`endif
                    OP_OUT: ld_out  = 1'b1;
                    OP_HLT: state_n = ST_HALT;
                    default: ;
                endcase
            end
            ST_T3: begin
                state_n = ST_T0;
                case (opc)
                    OP_LDA: ld_a_mem = 1'b1;
                    OP_ADD, OP_SUB: begin
                        ld_b    = 1'b1;
                        state_n = ST_T4;
                    end
                    OP_STA: ram_we = 1'b1;
                    default: ;
                endcase
            end
            ST_T4: begin
                ld_alu  = 1'b1;
                state_n = ST_T0;
            end
            ST_HALT: state_n = ST_HALT;
            default: state_n = ST_T0;
        endcase
    end

    always_ff @(posedge clk or negedge clear) begin
        if (!clear) begin
            pc        <= '0;
            mar       <= '0;
            ir        <= '0;
            a         <= '0;
            b         <= '0;
            carry     <= 1'b0;
            zero      <= 1'b0;
            out       <= '0;
            out_valid <= 1'b0;
        end else begin
            out_valid <= ld_out;
            if (ld_mar_pc) mar <= pc;
            if (ld_mar_op) mar <= operand;
            if (ld_ir) begin
                ir <= ram_rd;
                pc <= pc + 1'b1;
            end
            if (ld_pc_op) pc <= operand;
            if (ld_a_mem) a <= ram_rd;
            if (ld_a_imm) a <= {{(DATA_W-ADDR_W){1'b0}}, operand};
            if (ld_b)     b <= ram_rd;
            if (ld_alu) begin
                a     <= alu_res;
                carry <= alu_carry;
                zero  <= alu_zero;
            end
            if (ld_out) out <= a;
        end
    end

    // RAM is not reset; STA and host loads never coincide (STA only in T3).
    always_ff @(posedge clk) begin
        if (ram_we)       mem[mar]       <= a;
        else if (prog_ok) mem[prog_addr] <= prog_data;
    end

    assign halted    = (state == ST_HALT);
    assign dbg_state = state;
    assign dbg_pc    = pc;
    assign dbg_a     = a;
    assign dbg_carry = carry;
    assign dbg_zero  = zero;

endmodule

// File: tb/tb_ucomputer_gen.sv
module tb_ucomputer_gen;
    import ucomp_pkg::*;

    localparam int DATA_W = 8;
    localparam int ADDR_W = 4;
    localparam int OPC_W  = 4;
    localparam int DEPTH  = 16;
    localparam int MOD    = 256;
`ifdef UCOMP_BRANCH_EN
    localparam bit BRANCH_EN = 1'b1;
`else
    localparam bit BRANCH_EN = 1'b0;
`endif

    // ---------------- clock / reset / DUT ----------------
    logic              clk = 1'b0;
    logic              clear, run, prog_we;
    logic [ADDR_W-1:0] prog_addr;
    logic [DATA_W-1:0] prog_data;
    logic [DATA_W-1:0] out;
    logic              out_valid, halted;
    state_t            dbg_state;
    logic [ADDR_W-1:0] dbg_pc;
    logic [DATA_W-1:0] dbg_a;
    logic              dbg_carry, dbg_zero;

    always #5 clk = ~clk;

    ucomputer_gen #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .OPC_W(OPC_W)) dut (
        .clk       (clk),
        .clear     (clear),
        .run       (run),
        .prog_we   (prog_we),
        .prog_addr (prog_addr),
        .prog_data (prog_data),
        .out       (out),
        .out_valid (out_valid),
        .halted    (halted),
        .dbg_state (dbg_state),
        .dbg_pc    (dbg_pc),
        .dbg_a     (dbg_a),
        .dbg_carry (dbg_carry),
        .dbg_zero  (dbg_zero)
    );

    // ---------------- scoreboard ----------------
    int n_cmp = 0;
    int n_bad = 0;
    logic [DATA_W-1:0] exp_q[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Monitor: every out_valid cycle consumes one expected OUT value.
    always @(negedge clk) begin
        if (out_valid === 1'b1) begin
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL out_unexpected: got 0x%0h, expected no output", out);
            end else begin
                check("out_value", 32'(out), 32'(exp_q.pop_front()));
            end
        end
    end

    // ---------------- reference model (ISA level) ----------------
    logic [DATA_W-1:0] m_mem [DEPTH];
    int m_a, m_pc, m_cycles;
    bit m_carry, m_zero, m_halted;

    function automatic void model_reset();
        m_a = 0; m_pc = 0; m_cycles = 0;
        m_carry = 0; m_zero = 0; m_halted = 0;
    endfunction

    function automatic void clear_image();
        for (int i = 0; i < DEPTH; i++) m_mem[i] = '0;
    endfunction

    // Execute whole instructions; outputs go straight onto the expected queue.
    function automatic void model_run(input int max_instr);
        for (int k = 0; k < max_instr && !m_halted; k++) begin
            int w, op, opd, r, bv;
            w   = int'(m_mem[m_pc]);
            op  = w / 16;
            opd = w % 16;
            bv  = int'(m_mem[opd]);
            m_pc = (m_pc + 1) % DEPTH;
            case (op)
                1: begin m_a = bv; m_cycles += 4; end
                2: begin
                    r = m_a + bv;
                    m_carry = (r >= MOD);
                    m_a = r % MOD;
                    m_zero = (m_a == 0);
                    m_cycles += 5;
                end
                3: begin
                    m_carry = (m_a >= bv);
                    m_a = (m_a - bv + MOD) % MOD;
                    m_zero = (m_a == 0);
                    m_cycles += 5;
                end
                4: begin m_mem[opd] = 8'(m_a); m_cycles += 4; end
                5: begin m_a = opd; m_cycles += 3; end
                6, 7, 8: begin
                    if (BRANCH_EN && (op == 6 || (op == 7 && m_carry) || (op == 8 && m_zero)))
                        m_pc = opd;
                    m_cycles += 3;
                end
                14: begin exp_q.push_back(8'(m_a)); m_cycles += 3; end
                15: begin m_halted = 1; m_cycles += 3; end
                default: m_cycles += 3;
            endcase
        end
    endfunction

    // ---------------- driver tasks ----------------
    task automatic do_clear();
        clear = 1'b0; run = 1'b0; prog_we = 1'b0;
        @(negedge clk);
        clear = 1'b1;
        @(negedge clk);
    endtask

    task automatic load_words(input int lo, input int hi);
        for (int i = lo; i <= hi; i++) begin
            prog_we   = 1'b1;
            prog_addr = 4'(i);
            prog_data = m_mem[i];
            @(negedge clk);
        end
        prog_we = 1'b0;
    endtask

    task automatic run_until_halt(output int cycles);
        cycles = -1;
        run = 1'b1;
        for (int n = 1; n <= 2000; n++) begin
            @(negedge clk);
            if (halted === 1'b1) begin
                cycles = n;
                break;
            end
        end
        run = 1'b0;
        prog_we = 1'b0;
    endtask

    task automatic check_final(input string tag, input int cycles, input int exp_cycles);
        @(negedge clk);
        check({tag, "_cycles"}, 32'(cycles), 32'(exp_cycles));
        check({tag, "_halted"}, 32'(halted), 32'd1);
        check({tag, "_a"},      32'(dbg_a), 32'(m_a));
        check({tag, "_carry"},  32'(dbg_carry), 32'(m_carry));
        check({tag, "_zero"},   32'(dbg_zero), 32'(m_zero));
        check({tag, "_pc"},     32'(dbg_pc), 32'(m_pc));
        check({tag, "_drained"}, 32'(exp_q.size()), 32'd0);
        exp_q.delete();
    endtask

    task automatic run_program(input string tag);
        int c;
        do_clear();
        model_reset();
        load_words(0, DEPTH - 1);
        model_run(1000);
        run_until_halt(c);
        check_final(tag, c, m_cycles);
    endtask

    function automatic logic [7:0] rand_instr(input int addr);
        int sel;
        sel = $urandom_range(0, 11);
        case (sel)
            0:  return 8'h00;
            1:  return 8'(16 * 1 + $urandom_range(12, 15));
            2:  return 8'(16 * 2 + $urandom_range(12, 15));
            3:  return 8'(16 * 3 + $urandom_range(12, 15));
            4:  return 8'(16 * 4 + $urandom_range(13, 15));
            5:  return 8'(16 * 5 + $urandom_range(0, 15));
            7:  return 8'(16 * 6 + $urandom_range(12, addr + 1));
            8:  return 8'(16 * 7 + $urandom_range(12, addr + 1));
            9:  return 8'(16 * 8 + $urandom_range(12, addr + 1));
            10: return 8'(16 * $urandom_range(9, 13) + $urandom_range(0, 15));
            default: return 8'hE0;
        endcase
    endfunction

    // ---------------- stimulus ----------------
    initial begin
        int c, base;
        clear = 1'b0; run = 1'b0; prog_we = 1'b0;
        prog_addr = '0; prog_data = '0;

        // Reset and idle pause
        repeat (2) @(negedge clk);
        check("rst_out", 32'(out), 32'd0);
        check("rst_valid", 32'(out_valid), 32'd0);
        check("rst_halted", 32'(halted), 32'd0);
        check("rst_state", 32'(dbg_state), 32'(ST_T0));
        check("rst_pc", 32'(dbg_pc), 32'd0);
        check("rst_a", 32'(dbg_a), 32'd0);
        clear = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            check("idle_state", 32'(dbg_state), 32'(ST_T0));
        end
        check("idle_pc", 32'(dbg_pc), 32'd0);

        // Load / add
        clear_image();
        m_mem[0] = 8'h1E; m_mem[1] = 8'h2F; m_mem[2] = 8'hE0; m_mem[3] = 8'hF0;
        m_mem[14] = 8'h1C; m_mem[15] = 8'h0E;
        do_clear(); model_reset(); load_words(0, 15); model_run(1000);
        run_until_halt(c);
        check("add_cycles_15", 32'(c), 32'd15);
        check_final("add", c, m_cycles);

        // Carry + JC
        clear_image();
        m_mem[0] = 8'h1D; m_mem[1] = 8'h2E; m_mem[2] = 8'h76; m_mem[3] = 8'h53;
        m_mem[4] = 8'hE0; m_mem[5] = 8'hF0; m_mem[6] = 8'h57; m_mem[7] = 8'hE0;
        m_mem[8] = 8'hF0; m_mem[13] = 8'hF0; m_mem[14] = 8'h20;
        run_program("jc");
        check("jc_carry_set", 32'(dbg_carry), 32'd1);

        // SUB to zero + JZ, then SUB with borrow
        clear_image();
        m_mem[0] = 8'h1D; m_mem[1] = 8'h3E; m_mem[2] = 8'h85; m_mem[3] = 8'hE0;
        m_mem[4] = 8'hF0; m_mem[5] = 8'h51; m_mem[6] = 8'hE0; m_mem[7] = 8'hF0;
        m_mem[13] = 8'h05; m_mem[14] = 8'h05;
        run_program("jz");
        check("jz_zero_set", 32'(dbg_zero), 32'd1);
        clear_image();
        m_mem[0] = 8'h1D; m_mem[1] = 8'h3E; m_mem[2] = 8'hE0; m_mem[3] = 8'hF0;
        m_mem[13] = 8'h03; m_mem[14] = 8'h05;
        run_program("borrow");
        check("borrow_a_fe", 32'(dbg_a), 32'hFE);

        // PC wrap: program rewrites address 0 to HLT, then runs off the end
        clear_image();
        m_mem[1] = 8'h14; m_mem[2] = 8'h24; m_mem[3] = 8'h40;
        m_mem[4] = 8'h78; m_mem[5] = 8'hE0;
        run_program("wrap");

        // Pause mid-ADD, load while paused, ignored load while running
        clear_image();
        m_mem[0] = 8'h1E; m_mem[1] = 8'h2F; m_mem[2] = 8'h00; m_mem[3] = 8'hF0;
        m_mem[14] = 8'h1C; m_mem[15] = 8'h0E;
        do_clear(); model_reset(); load_words(0, 15); model_run(2);
        run = 1'b1;
        repeat (6) @(negedge clk);
        check("pause_in_add", 32'(dbg_state), 32'(ST_T2));
        run = 1'b0;
        repeat (10) @(negedge clk);
        check("pause_state", 32'(dbg_state), 32'(ST_T0));
        check("pause_pc", 32'(dbg_pc), 32'(m_pc));
        check("pause_a", 32'(dbg_a), 32'(m_a));
        m_mem[2] = 8'hE0;
        load_words(2, 2);
        base = m_cycles;
        model_run(1000);
        prog_we = 1'b1; prog_addr = 4'd3; prog_data = 8'hE0;
        run_until_halt(c);
        check_final("resume", c, m_cycles - base);

        // Asynchronous clear during STA T2 discards the store
        clear_image();
        m_mem[0] = 8'h59; m_mem[1] = 8'h4C; m_mem[2] = 8'hF0; m_mem[12] = 8'h33;
        do_clear(); load_words(0, 15);
        run = 1'b1;
        repeat (5) @(negedge clk);
        check("sta_t2", 32'(dbg_state), 32'(ST_T2));
        clear = 1'b0; run = 1'b0;
        #1;
        check("clr_state", 32'(dbg_state), 32'(ST_T0));
        check("clr_pc", 32'(dbg_pc), 32'd0);
        check("clr_a", 32'(dbg_a), 32'd0);
        @(negedge clk);
        clear = 1'b1;
        @(negedge clk);
        m_mem[0] = 8'h1C; m_mem[1] = 8'hE0; m_mem[2] = 8'hF0;
        load_words(0, 2);
        model_reset(); model_run(1000);
        run_until_halt(c);
        check_final("clr_sta", c, m_cycles);

        // Randomised forward-flow programs
        for (int t = 0; t < 20; t++) begin
            for (int i = 0; i < 12; i++) m_mem[i] = rand_instr(i);
            m_mem[12] = 8'hF0;
            for (int i = 13; i < DEPTH; i++)
                m_mem[i] = $urandom_range(0, 1) ? 8'($urandom_range(0, 3)) : 8'($urandom_range(0, 255));
            run_program($sformatf("rand%0d", t));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
